counter_sweep_ctrl: RTL and testbench

Sequencer for the team's up/down counter. It drives the counter's enable, set, set_value and up_down inputs and watches its count output. It loads a start value, then sweeps between programmable low and high limits at a programmable step rate. Two modes: one-shot (lo to hi) and ping-pong (lo to hi to lo, repeated N passes). Sits between the config/control logic and the counter instance.

---
 rtl/counter_sweep_pkg.sv | 18 +
 rtl/sweep_tick_gen.sv | 26 ++
 rtl/counter_sweep_ctrl.sv | 163 ++++++++++++++++
 tb/tb_counter_sweep_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/counter_sweep_pkg.sv
// Shared types and constants for the counter sweep sequencer.
package counter_sweep_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        UP,
        DOWN,
        DONE
    } state_t;

    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_PINGPONG = 1'b1;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/sweep_tick_gen.sv
// Step-rate prescaler: counts 0..rate and asserts tick on the terminal value.
module sweep_tick_gen #(
    parameter int RATE_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic [RATE_W-1:0] rate,
    output logic              tick
);

    logic [RATE_W-1:0] pre;

    assign tick = (pre == rate);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pre <= '0;
        end else if (clear || tick) begin
            pre <= '0;
        end else begin
            pre <= pre + 1'b1;
        end
    end

endmodule

// File: rtl/counter_sweep_ctrl.sv
// Sequencer that loads an up/down counter and sweeps it between lo and hi.
module counter_sweep_ctrl
    import counter_sweep_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int RATE_W = 8,
    parameter int PASS_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [WIDTH-1:0]  lo,
    input  logic [WIDTH-1:0]  hi,
    input  logic              mode,
    input  logic [PASS_W-1:0] passes,
    input  logic [RATE_W-1:0] rate,
    input  logic [WIDTH-1:0]  count_in,
    output logic              cnt_enable,
    output logic              cnt_set,
    output logic [WIDTH-1:0]  cnt_set_value,
    output logic              cnt_up_down,
    output logic              busy,
    output logic              done,
    output logic              err
);

    state_t            state;
    state_t            state_next;

    logic [WIDTH-1:0]  lo_q;
    logic [WIDTH-1:0]  hi_q;
    logic              mode_q;
    logic [PASS_W-1:0] passes_q;
    logic [RATE_W-1:0] rate_q;
    logic [PASS_W-1:0] pass_cnt;
    logic [PASS_W-1:0] pass_nxt;

    logic              tick;
    logic              at_hi;
    logic              at_lo;
    logic              latch;
    logic              reject;
    logic              pass_inc;
    logic              pass_clr;

    assign at_hi    = (count_in == hi_q);
    assign at_lo    = (count_in == lo_q);
    assign pass_nxt = pass_cnt + 1'b1;

    // Prescaler restarts whenever the state is about to change.
    sweep_tick_gen #(
        .RATE_W (RATE_W)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .clear (state_next != state),
        .rate  (rate_q),
        .tick  (tick)
    );

    always_comb begin
        state_next    = state;
        cnt_enable    = 1'b0;
        cnt_set       = 1'b0;
        cnt_set_value = '0;
        cnt_up_down   = DIR_DOWN;
        latch         = 1'b0;
        reject        = 1'b0;
        pass_inc      = 1'b0;
        pass_clr      = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    latch = 1'b1;
                    if (lo > hi) begin
                        reject = 1'b1;
                    end else begin
                        pass_clr   = 1'b1;
                        state_next = LOAD;
                    end
                end
            end
            LOAD: begin
                cnt_set_value = lo_q;
                if (abort) begin
                    state_next = IDLE;
                end else begin
                    cnt_set    = 1'b1;
                    state_next = UP;
                end
            end
            UP: begin
                cnt_up_down = DIR_UP;
                if (abort) begin
                    state_next = IDLE;
                end else begin
                    // Enable is masked at the limit so the counter never overshoots.
                    cnt_enable = tick & ~at_hi;
                    if (at_hi) begin
                        state_next = (mode_q == MODE_PINGPONG) ? DOWN : DONE;
                    end
                end
            end
            DOWN: begin
                cnt_up_down = DIR_DOWN;
                if (abort) begin
                    state_next = IDLE;
                end else begin
                    cnt_enable = tick & ~at_lo;
                    if (at_lo) begin
                        pass_inc = 1'b1;
                        if ((passes_q != '0) && (pass_nxt == passes_q)) begin
                            state_next = DONE;
                        end else begin
                            state_next = UP;
                        end
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy = (state == LOAD) || (state == UP) || (state == DOWN);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            lo_q     <= '0;
            hi_q     <= '0;
            mode_q   <= 1'b0;
            passes_q <= '0;
            rate_q   <= '0;
            pass_cnt <= '0;
            err      <= 1'b0;
        end else begin
            state <= state_next;
            err   <= reject;
            if (latch) begin
                lo_q     <= lo;
                hi_q     <= hi;
                mode_q   <= mode;
                passes_q <= passes;
                rate_q   <= rate;
            end
            // Saturate so an endless ping-pong never wraps the pass count.
            if (pass_clr) begin
                pass_cnt <= '0;
            end else if (pass_inc && (pass_cnt != '1)) begin
                pass_cnt <= pass_nxt;
            end
        end
    end

endmodule

// File: tb/tb_counter_sweep_ctrl.sv
// Directed bench for counter_sweep_ctrl driving a behavioural up/down counter.
module tb_counter_sweep_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       abort;
    logic [3:0] lo;
    logic [3:0] hi;
    logic       mode;
    logic [3:0] passes;
    logic [7:0] rate;
    logic [3:0] count = 4'd0;
    logic       cnt_enable;
    logic       cnt_set;
    logic [3:0] cnt_set_value;
    logic       cnt_up_down;
    logic       busy;
    logic       done;
    logic       err;

    int n_cmp = 0;
    int n_bad = 0;

    counter_sweep_ctrl #(
        .WIDTH  (4),
        .RATE_W (8),
        .PASS_W (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .abort         (abort),
        .lo            (lo),
        .hi            (hi),
        .mode          (mode),
        .passes        (passes),
        .rate          (rate),
        .count_in      (count),
        .cnt_enable    (cnt_enable),
        .cnt_set       (cnt_set),
        .cnt_set_value (cnt_set_value),
        .cnt_up_down   (cnt_up_down),
        .busy          (busy),
        .done          (done),
        .err           (err)
    );

    always #5 clk = ~clk;

    // The controlled counter.
    always @(posedge clk) begin
        if (cnt_set)
            count <= cnt_set_value;
        else if (cnt_enable)
            count <= cnt_up_down ? count + 4'd1 : count - 4'd1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues start in cycle 0 and returns in cycle 1 (the LOAD cycle).
    task automatic start_sweep(input logic [3:0] l, input logic [3:0] h, input logic m,
                               input logic [3:0] p, input logic [7:0] r);
        lo = l; hi = h; mode = m; passes = p; rate = r;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int oneshot_cnt[4]  = '{2, 3, 4, 5};
        int pp_cnt[12]      = '{1, 2, 3, 3, 2, 1, 1, 2, 3, 3, 2, 1};
        int pp_dir[12]      = '{1, 1, 1, 0, 0, 0, 1, 1, 1, 0, 0, 0};
        int rt_en[9]        = '{0, 0, 0, 1, 0, 0, 0, 1, 0};
        int rt_cnt[9]       = '{0, 0, 0, 0, 1, 1, 1, 1, 2};

        reset = 1'b1; start = 1'b0; abort = 1'b0;
        lo = '0; hi = '0; mode = 1'b0; passes = '0; rate = '0;
        #1 reset = 1'b0;
        step(); step();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_en", cnt_enable, 0);
        chk("rst_set", cnt_set, 0);
        chk("rst_dir", cnt_up_down, 0);
        #2 reset = 1'b1;
        step();

        // One-shot, lo=2 hi=5 rate=0
        start_sweep(4'd2, 4'd5, 1'b0, 4'd0, 8'd0);
        chk("os_load_busy", busy, 1);
        chk("os_load_set", cnt_set, 1);
        chk("os_load_val", cnt_set_value, 2);
        step();
        for (int i = 0; i < 4; i++) begin
            chk("os_cnt", count, oneshot_cnt[i]);
            chk("os_en", cnt_enable, (i < 3) ? 1 : 0);
            chk("os_dir", cnt_up_down, 1);
            chk("os_nodone", done, 0);
            step();
        end
        chk("os_done", done, 1);
        chk("os_done_busy", busy, 0);
        chk("os_hold5", count, 5);
        step();
        chk("os_done_pulse", done, 0);
        chk("os_no6", count, 5);

        // Ping-pong, lo=1 hi=3 passes=2
        start_sweep(4'd1, 4'd3, 1'b1, 4'd2, 8'd0);
        chk("pp_load_val", cnt_set_value, 1);
        step();
        for (int i = 0; i < 12; i++) begin
            chk("pp_cnt", count, pp_cnt[i]);
            chk("pp_dir", cnt_up_down, pp_dir[i]);
            chk("pp_nodone", done, 0);
            chk("pp_busy", busy, 1);
            step();
        end
        chk("pp_done", done, 1);
        chk("pp_done_busy", busy, 0);
        step();
        chk("pp_after_done", done, 0);
        chk("pp_after_busy", busy, 0);

        // Rate=3, one-shot, lo=0 hi=2
        start_sweep(4'd0, 4'd2, 1'b0, 4'd0, 8'd3);
        step();
        for (int i = 0; i < 9; i++) begin
            chk("rt_en", cnt_enable, rt_en[i]);
            chk("rt_cnt", count, rt_cnt[i]);
            chk("rt_nodone", done, 0);
            step();
        end
        chk("rt_done", done, 1);
        chk("rt_final", count, 2);
        step();

        // Rejected start: lo > hi
        start_sweep(4'd7, 4'd3, 1'b0, 4'd0, 8'd0);
        chk("err_pulse", err, 1);
        chk("err_busy", busy, 0);
        chk("err_set", cnt_set, 0);
        step();
        chk("err_clear", err, 0);
        chk("err_busy2", busy, 0);
        chk("err_set2", cnt_set, 0);

        // Endless ping-pong, abort mid-DOWN
        start_sweep(4'd1, 4'd3, 1'b1, 4'd0, 8'd0);
        for (int i = 0; i < 5; i++) step();
        chk("ab_cnt", count, 2);
        chk("ab_dir", cnt_up_down, 0);
        chk("ab_en_pre", cnt_enable, 1);
        abort = 1'b1;
        #1;
        chk("ab_en", cnt_enable, 0);
        chk("ab_busy", busy, 1);
        step();
        abort = 1'b0;
        chk("ab_idle", busy, 0);
        chk("ab_nodone", done, 0);
        chk("ab_hold", count, 2);
        step();
        chk("ab_hold2", count, 2);
        chk("ab_nodone2", done, 0);

        // Asynchronous reset mid-UP, then a fresh sweep
        start_sweep(4'd0, 4'd3, 1'b0, 4'd0, 8'd0);
        step(); step();
        chk("ar_busy_pre", busy, 1);
        #2 reset = 1'b0;
        #1;
        chk("ar_busy", busy, 0);
        chk("ar_en", cnt_enable, 0);
        chk("ar_dir", cnt_up_down, 0);
        chk("ar_set", cnt_set, 0);
        chk("ar_val", cnt_set_value, 0);
        chk("ar_done", done, 0);
        chk("ar_err", err, 0);
        step();
        #2 reset = 1'b1;
        step();
        start_sweep(4'd0, 4'd1, 1'b0, 4'd0, 8'd0);
        chk("ar2_set", cnt_set, 1);
        chk("ar2_val", cnt_set_value, 0);
        step();
        chk("ar2_cnt0", count, 0);
        chk("ar2_en0", cnt_enable, 1);
        step();
        chk("ar2_cnt1", count, 1);
        chk("ar2_en1", cnt_enable, 0);
        step();
        chk("ar2_done", done, 1);
        step();
        chk("ar2_idle_done", done, 0);
        chk("ar2_idle_busy", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
